// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: FSM states, command codes and status bit positions shared by the SPI register-file slave
package spi_slave_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DROP} state_t;
    typedef enum logic [1:0] {OP_WR, OP_RD, OP_ST} op_t;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_READ = 4'h2;
    localparam logic [3:0] CMD_RDSTAT = 4'h5;
    localparam int STAT_ERR = 0;
    localparam int STAT_LWW = 1;
endpackage

// File: rtl/spi_slave_regfile_if.sv
// spi_slave_regfile_if: SPI pins between a bus master and the register-file slave
interface spi_slave_regfile_if;
    logic SSB;
    logic MOSI;
    logic MISO;
    modport master (output SSB, output MOSI, input MISO);
    modport slave (input SSB, input MOSI, output MISO);
endinterface

// File: rtl/spi_regfile.sv
// spi_regfile: DEPTH x DW storage with one synchronous write port and one asynchronous read port
module spi_regfile #(
    parameter int DW = 8,
    parameter int DEPTH = 16,
    localparam int RW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = 32'(raddr) < DEPTH ? mem_q[raddr] : '0;
endmodule

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI slave (cmd, addr, data words) fronting a register file.
// Define SPI_SLAVE_AUTOINC_EN to advance the address after every data word.
module spi_slave_regfile
    import spi_slave_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int DEPTH = 16
) (
    input  logic                      SCK,
    input  logic                      reset,
    spi_slave_regfile_if.slave        sif,
    output logic                      frame_active,
    output logic                      wr_pulse,
    output logic [AW-1:0]             wr_addr,
    output logic [DW-1:0]             wr_data
);
    localparam int CW = $clog2(DW);
    localparam int RW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    state_t state_q, state_d;
    op_t op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-2:0] sh_q, sh_d;
    logic [DW-1:0] tx_q, tx_d, wr_data_q, wr_data_d, word, rdata, stat;
    logic [AW-1:0] addr_q, addr_d, addr_nxt, raddr, wr_addr_q, wr_addr_d;
    logic err_q, err_d, lww_q, lww_d, wr_pulse_q, wr_pulse_d;
    logic done, known, rd_ok, wr_ok;
    assign word = {sh_q, sif.MOSI};
    assign done = cnt_q == CW'(DW - 1);
    assign known = word[3:0] == CMD_WRITE || word[3:0] == CMD_READ || word[3:0] == CMD_RDSTAT;
`ifdef SPI_SLAVE_AUTOINC_EN
    assign addr_nxt = addr_q == AW'(DEPTH - 1) ? '0 : addr_q + AW'(1);
`else
    assign addr_nxt = addr_q;
`endif
    // the read port looks at the address being completed, else at the next data word's address
    assign raddr = state_q == ADDR ? word[AW-1:0] : addr_nxt;
    assign rd_ok = 32'(raddr) < DEPTH;
    assign wr_ok = 32'(addr_q) < DEPTH;
    always_comb begin
        stat = '0;
        stat[STAT_ERR] = err_q;
        stat[STAT_LWW] = lww_q;
    end
    spi_regfile #(.DW(DW), .DEPTH(DEPTH)) u_rf (
        .clk(SCK),
        .we(wr_pulse_d && !reset),
        .waddr(addr_q[RW-1:0]),
        .wdata(word),
        .raddr(raddr[RW-1:0]),
        .rdata(rdata)
    );
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        cnt_d = done ? '0 : cnt_q + CW'(1);
        sh_d = word[DW-2:0];
        addr_d = addr_q;
        tx_d = state_q == DATA ? tx_q << 1 : tx_q;
        err_d = err_q;
        lww_d = lww_q;
        wr_pulse_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (sif.SSB) begin
            state_d = IDLE;
            cnt_d = '0;
            sh_d = '0;
        end else if (state_q == IDLE) begin
            state_d = CMD;
            cnt_d = CW'(1);
            sh_d = (DW-1)'(sif.MOSI);
        end else if (done && state_q == CMD) begin
            state_d = !known ? DROP : word[3:0] == CMD_RDSTAT ? DATA : ADDR;
            op_d = word[3:0] == CMD_WRITE ? OP_WR : word[3:0] == CMD_READ ? OP_RD : OP_ST;
            tx_d = word[3:0] == CMD_RDSTAT ? stat : '0;
            err_d = err_q | !known;
        end else if (done && state_q == ADDR) begin
            state_d = DATA;
            addr_d = word[AW-1:0];
            if (op_q == OP_RD) begin
                tx_d = rd_ok ? rdata : '0;
                err_d = err_q | !rd_ok;
                lww_d = 1'b0;
            end
        end else if (done && state_q == DATA) begin
            addr_d = addr_nxt;
            if (op_q == OP_RD) begin
                tx_d = rd_ok ? rdata : '0;
                err_d = err_q | !rd_ok;
            end else if (op_q == OP_WR) begin
                wr_pulse_d = wr_ok;
                wr_addr_d = wr_ok ? addr_q : wr_addr_q;
                wr_data_d = wr_ok ? word : wr_data_q;
                lww_d = lww_q | wr_ok;
                err_d = err_q | !wr_ok;
            end else begin
                err_d = 1'b0;
            end
        end
    end
    always_ff @(posedge SCK) begin
        if (reset) begin
            state_q <= IDLE;
            op_q <= OP_WR;
            cnt_q <= '0;
            sh_q <= '0;
            addr_q <= '0;
            tx_q <= '0;
            err_q <= 1'b0;
            lww_q <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            addr_q <= addr_d;
            tx_q <= tx_d;
            err_q <= err_d;
            lww_q <= lww_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
    assign sif.MISO = state_q == DATA && tx_q[DW-1];
    assign frame_active = state_q != IDLE;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: random frames against a transaction-level model, plus directed corner cases.
// Two slaves share the bus: DEPTH=16 (index 0) and DEPTH=12 (index 1).
module tb_spi_slave_regfile;
    logic sck = 1'b0;
    logic rst = 1'b1;
    logic ssb = 1'b1;
    logic mosi = 1'b0;
    logic [1:0] fa, wp, miso;
    logic [1:0][3:0] wa;
    logic [1:0][7:0] wd;
    int n_chk = 0;
    int n_err = 0;
    int bitn, pbit;
    int np[2];
    int exp_np[2];
    logic [7:0] rx_b[2];
    logic [7:0] dat[8];
    logic [7:0] mem_m[2][16];
    logic [7:0] exp_w[2][8];
    logic err_m[2], lww_m[2];
    logic [3:0] wa_m[2];
    logic [7:0] wd_m[2];
    spi_slave_regfile_if bus();
    spi_slave_regfile_if bus12();
    assign bus.SSB = ssb;
    assign bus.MOSI = mosi;
    assign bus12.SSB = ssb;
    assign bus12.MOSI = mosi;
    assign miso = {bus12.MISO, bus.MISO};
    spi_slave_regfile dut (.SCK(sck), .reset(rst), .sif(bus), .frame_active(fa[0]),
        .wr_pulse(wp[0]), .wr_addr(wa[0]), .wr_data(wd[0]));
    spi_slave_regfile #(.DEPTH(12)) dut12 (.SCK(sck), .reset(rst), .sif(bus12), .frame_active(fa[1]),
        .wr_pulse(wp[1]), .wr_addr(wa[1]), .wr_data(wd[1]));
    always #5 sck = ~sck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int depth(input int k);
        return k == 0 ? 16 : 12;
    endfunction

    function automatic logic [3:0] nxt(input int k, input logic [3:0] a);
`ifdef SPI_SLAVE_AUTOINC_EN
        return int'(a) == depth(k) - 1 ? 4'd0 : a + 4'd1;
`else
        return a + 4'd0 * 4'(k);
`endif
    endfunction

    task automatic model_frame(input int k, input logic [7:0] cmd, input logic [7:0] adr, input int nw);
        logic [3:0] a;
        a = adr[3:0];
        exp_np[k] = 0;
        for (int j = 0; j < 8; j++) exp_w[k][j] = 8'h00;
        case (cmd[3:0])
            4'h5: begin
                exp_w[k][0] = {6'd0, lww_m[k], err_m[k]};
                if (nw > 0) err_m[k] = 1'b0;
            end
            4'h2: begin
                lww_m[k] = 1'b0;
                for (int j = 0; j <= nw; j++) begin
                    if (int'(a) < depth(k)) begin
                        if (j < nw) exp_w[k][j] = mem_m[k][a];
                    end else err_m[k] = 1'b1;
                    a = nxt(k, a);
                end
            end
            4'h1: begin
                for (int j = 0; j < nw; j++) begin
                    if (int'(a) < depth(k)) begin
                        mem_m[k][a] = dat[j];
                        exp_np[k]++;
                        wa_m[k] = a;
                        wd_m[k] = dat[j];
                        lww_m[k] = 1'b1;
                    end else err_m[k] = 1'b1;
                    a = nxt(k, a);
                end
            end
            default: err_m[k] = 1'b1;
        endcase
    endtask

    task automatic sbit(input logic b);
        @(negedge sck);
        ssb = 1'b0;
        mosi = b;
        rx_b[0] = {rx_b[0][6:0], miso[0]};
        rx_b[1] = {rx_b[1][6:0], miso[1]};
        @(posedge sck);
        #1;
        bitn++;
        for (int k = 0; k < 2; k++) begin
            if (wp[k]) begin
                np[k]++;
                if (k == 0 && pbit == 0) pbit = bitn;
            end
        end
    endtask

    task automatic sbyte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sbit(b[i]);
    endtask

    task automatic end_frame();
        @(negedge sck);
        ssb = 1'b1;
        @(posedge sck);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge sck);
        rst = 1'b1;
        @(posedge sck);
        #1;
        for (int k = 0; k < 2; k++) begin
            err_m[k] = 1'b0;
            lww_m[k] = 1'b0;
            wa_m[k] = 4'd0;
            wd_m[k] = 8'd0;
        end
        chk({tag, "_fa"}, 32'(fa), 32'd0);
        chk({tag, "_wp"}, 32'(wp), 32'd0);
        chk({tag, "_miso"}, 32'(miso), 32'd0);
        chk({tag, "_wa"}, 32'(wa), 32'd0);
        chk({tag, "_wd"}, 32'(wd), 32'd0);
        @(negedge sck);
        rst = 1'b0;
        ssb = 1'b1;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] adr, input int nw, input string tag);
        for (int k = 0; k < 2; k++) model_frame(k, cmd, adr, nw);
        bitn = 0;
        pbit = 0;
        np = '{0, 0};
        sbyte(cmd);
        chk({tag, "_active"}, 32'(fa), 32'd3);
        if (cmd[3:0] == 4'h1 || cmd[3:0] == 4'h2) sbyte(adr);
        for (int j = 0; j < nw; j++) begin
            sbyte(dat[j]);
            for (int k = 0; k < 2; k++) chk($sformatf("%s_w%0d_d%0d", tag, j, k), 32'(rx_b[k]), 32'(exp_w[k][j]));
        end
        end_frame();
        chk({tag, "_idle"}, 32'(fa), 32'd0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_npulse_d%0d", tag, k), 32'(np[k]), 32'(exp_np[k]));
            chk($sformatf("%s_wa_d%0d", tag, k), 32'(wa[k]), 32'(wa_m[k]));
            chk($sformatf("%s_wd_d%0d", tag, k), 32'(wd[k]), 32'(wd_m[k]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c;
        int r;
        do_reset("rst0");
        for (int a = 0; a < 16; a++) begin
            dat[0] = 8'($urandom);
            frame(8'h01, 8'(a), 1, "init");
        end
        do_reset("rst1");
        dat[0] = 8'h3C;
        dat[1] = 8'hC3;
        frame(8'h07, 8'h00, 2, "drop");
        frame(8'h05, 8'h00, 1, "stat1");
        chk("stat1_val", 32'(rx_b[0]), 32'h01);
        frame(8'h05, 8'h00, 1, "stat2");
        chk("stat2_val", 32'(rx_b[0]), 32'h00);
        dat[0] = 8'hA5;
        frame(8'h01, 8'h03, 1, "wr3");
        chk("wr3_pulse_bit", 32'(pbit), 32'd24);
        chk("wr3_addr", 32'(wa[0]), 32'd3);
        chk("wr3_data", 32'(wd[0]), 32'hA5);
        frame(8'h02, 8'h03, 1, "rd3");
        chk("rd3_val", 32'(rx_b[0]), 32'hA5);
        dat[0] = 8'h11;
        dat[1] = 8'h22;
        frame(8'h01, 8'h0F, 2, "wrap");
        frame(8'h02, 8'h0F, 1, "rd15");
`ifdef SPI_SLAVE_AUTOINC_EN
        chk("rd15_val", 32'(rx_b[0]), 32'h11);
        frame(8'h02, 8'h00, 1, "rd0");
        chk("rd0_val", 32'(rx_b[0]), 32'h22);
`else
        chk("rd15_val", 32'(rx_b[0]), 32'h22);
`endif
        bitn = 0;
        sbyte(8'h01);
        for (int i = 0; i < 5; i++) sbit(1'b1);
        end_frame();
        chk("abort_idle", 32'(fa), 32'd0);
        dat[0] = 8'h00;
        frame(8'h02, 8'h07, 1, "post_abort");
        bitn = 0;
        np = '{0, 0};
        sbyte(8'h01);
        sbyte(8'h05);
        for (int i = 0; i < 4; i++) sbit(1'b1);
        do_reset("rst_mid");
        chk("rst_mid_npulse", 32'(np[0] + np[1]), 32'd0);
        frame(8'h02, 8'h05, 1, "keep5");
        frame(8'h02, 8'h0D, 1, "rd13");
        chk("rd13_val12", 32'(rx_b[1]), 32'h00);
        frame(8'h05, 8'h00, 1, "st13");
        chk("st13_err12", 32'(rx_b[1][0]), 32'd1);
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4) c = 4'h1;
            else if (r < 7) c = 4'h2;
            else if (r < 9) c = 4'h5;
            else begin
                c = 4'($urandom);
                if (c == 4'h1 || c == 4'h2 || c == 4'h5) c = 4'h9;
            end
            for (int j = 0; j < 8; j++) dat[j] = 8'($urandom);
            frame({4'($urandom), c}, 8'($urandom), $urandom_range(1, 3), $sformatf("rnd%0d", i));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the width of the command, address and data words in bits (DW >= 8).
REQ-002 SHALL have parameter AW, default 4, meaning the number of address bits used from the address word (AW <= DW).
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of register-file words (DEPTH <= 2**AW).
REQ-004 SHALL have port SCK, input, 1 bit: the sole clock; all logic acts on the posedge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port SSB, input, 1 bit: active-low slave select, sampled on SCK.
REQ-007 SHALL have port MOSI, input, 1 bit: serial data in, MSB first.
REQ-008 SHALL have port MISO, output, 1 bit: serial data out, MSB first.
REQ-009 SHALL have port frame_active, output, 1 bit: high while the FSM is not in IDLE.
REQ-010 SHALL have port wr_pulse, output, 1 bit: one-cycle strobe on each register-file write.
REQ-011 SHALL have port wr_addr, output, AW bits: the address of the current write.
REQ-012 SHALL have port wr_data, output, DW bits: the data of the current write.

Function
REQ-013 SHALL implement FSM states IDLE, CMD, ADDR, DATA and DROP.
REQ-014 SHALL, on an SCK posedge with SSB=1 in any state, go to IDLE, clear the bit counter and discard any partial word.
REQ-015 SHALL, in IDLE on a posedge with SSB=0, shift MOSI in as CMD bit 0, set bit counter=1 and enter CMD.
REQ-016 SHALL complete a word on the posedge where bit counter==DW-1, then reset the counter to 0 on the next bit.
REQ-017 SHALL decode the command from cmd[3:0]: 0x1 WRITE, 0x2 READ, 0x5 RDSTAT; any other value enters DROP and sets the err flag.
REQ-018 SHALL, for RDSTAT, go from CMD directly to DATA and load the status word {zeros, last_was_write, err} into the TX shifter on the completing edge.
REQ-019 SHALL, for WRITE or READ, enter ADDR and latch addr = word[AW-1:0] when the address word completes.
REQ-020 SHALL, for READ, load the TX shifter with mem[addr] on the edge completing the address word, or with 0 and set err if addr >= DEPTH.
REQ-021 SHALL drive MISO combinationally from TX shifter MSB; the TX shifter shifts left on each DATA-state posedge, and MISO=0 outside DATA.
REQ-022 SHALL, for WRITE, on each completed data word assert wr_pulse for exactly that cycle and write mem[addr]; addr >= DEPTH suppresses both the write and wr_pulse and sets err.
REQ-023 SHALL clear err when a RDSTAT data word completes; an error occurring on the same edge takes priority and leaves err set.
REQ-024 SHALL remain in DROP, ignoring MOSI, until SSB=1.
REQ-025 SHALL keep wr_addr and wr_data at the last written values between writes.

Reset
REQ-026 SHALL, on reset=1 at a posedge, even mid-frame, put FSM=IDLE, bit counter=0, err=0, last_was_write=0, wr_pulse=0, wr_addr=0, wr_data=0 and TX shifter=0, so MISO=0.
REQ-027 SHALL NOT clear register-file contents on reset.
REQ-028 SHALL give reset priority over SSB.

Configuration
REQ-029 SHALL, with SPI_SLAVE_AUTOINC_EN defined, increment addr after each DATA word, wrapping from DEPTH-1 to 0, and preload the next read word on the completing edge.
REQ-030 SHALL, without SPI_SLAVE_AUTOINC_EN, hold addr fixed so repeated words rewrite or re-read the same register.

Structure
REQ-031 SHALL place the state enum, the command code constants and the status bit positions in package spi_slave_pkg.
REQ-032 SHALL implement storage as sub-module spi_regfile: parameters DW and DEPTH, one synchronous write port and one asynchronous read port.

Verification
REQ-033 SHALL verify that WRITE 0x01, addr 0x03, data 0xA5 gives wr_pulse on bit 24, wr_addr=3, wr_data=0xA5, and a following READ of addr 3 returns 0xA5 on MISO.
REQ-034 SHALL verify, with AUTOINC, that WRITE at addr 0x0F with data 0x11 then 0x22 writes mem[15]=0x11 and mem[0]=0x22 (wrap).
REQ-035 SHALL verify that cmd 0x07 enters DROP, produces no wr_pulse, and a subsequent RDSTAT returns 0x01 followed by 0x00 on a second RDSTAT.
REQ-036 SHALL verify that SSB=1 after 5 bits of an address word returns the FSM to IDLE, and the next frame decodes normally.
REQ-037 SHALL verify that reset asserted mid-DATA gives FSM=IDLE, MISO=0, no wr_pulse, and that register contents are preserved.
REQ-038 SHALL verify, with DEPTH=12, that a READ of addr 13 returns 0x00 and sets err.
